// File: rtl/fec_pkg.sv
// Shared FEC-path definitions.
//   RS_N / RS_K / RS_NSYM : RS(544,514) codeword, message and parity symbol counts
//   SYM_W                 : RS symbol width in bits
//   PMA_W                 : PMA interface word width in bits
//   gb_state_t            : gearbox codeword-tracking state
package fec_pkg;

  localparam int RS_N    = 544;
  localparam int RS_K    = 514;
  localparam int RS_NSYM = 30;
  localparam int SYM_W   = 10;
  localparam int PMA_W   = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } gb_state_t;

endpackage

// File: rtl/fec_sync_fifo.sv
// Small synchronous FIFO with the head entry presented directly from storage.
//   clk, rst  : clock, synchronous active-high reset (clears storage too)
//   wr_en     : push wr_data; ignored when full unless a pop happens the same cycle
//   wr_data   : entry to push
//   rd_en     : pop the head entry; ignored when empty
//   rd_data   : head entry (valid when !empty)
//   full      : DEPTH entries held
//   empty     : no entries held
module fec_sync_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  // Pointers wrap naturally, so the depth has to be a power of two.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fec_sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign rd_data = mem[rd_ptr];

  // A push into a full FIFO is accepted when the head is popped on the same
  // edge: wr_ptr == rd_ptr then, and the slot being overwritten is the one
  // leaving.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rs_cw_gearbox.sv
// RS codeword symbol -> PMA word gearbox.
// Packs the RS encoder's 10-bit symbol stream LSB-first into 64-bit words,
// tags the first and last word of each 544-symbol codeword and buffers the
// words in a small FIFO so the PMA side can stall briefly.
//   clk, rst   : clock, synchronous active-high reset
//   valid_in   : symbol valid (no backpressure toward the encoder)
//   data_in    : codeword symbol
//   out_valid  : head word valid
//   out_ready  : head word consumed on out_valid && out_ready
//   out_data   : packed word, bit 0 = bit 0 of the earliest symbol
//   out_sop    : head word is word 0 of a codeword
//   out_eop    : head word is the last word of a codeword
//   overflow   : sticky, a completed word was dropped on a full FIFO
//   busy       : a codeword is partially received
//
// Output handshake: a word transfers on every rising edge where out_valid
// and out_ready are both high; out_valid/out_data/out_sop/out_eop stay
// stable until that transfer, and out_ready may toggle freely.
module rs_cw_gearbox #(
  parameter int N          = fec_pkg::RS_N,
  parameter int SYM_W      = fec_pkg::SYM_W,
  parameter int OUT_W      = fec_pkg::PMA_W,
  parameter int WORDS      = 85,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [SYM_W-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             overflow,
  output logic             busy
);

  import fec_pkg::*;

  localparam int ACC_W = OUT_W + SYM_W;
  localparam int FW    = $clog2(OUT_W);
  localparam int FS_W  = FW + 1;
  localparam int SC_W  = $clog2(N);
  localparam int WC_W  = $clog2(WORDS);
  localparam int FF_W  = OUT_W + 2;

  // Codeword boundaries only line up with word boundaries if the codeword
  // bit count is an exact multiple of the word width.
  if (N * SYM_W != WORDS * OUT_W) begin : g_bad_words
    $error("rs_cw_gearbox: N*SYM_W must equal WORDS*OUT_W");
  end

  gb_state_t        state;
  logic [ACC_W-1:0] acc;
  logic [FW-1:0]    fill;
  logic [SC_W-1:0]  sym_cnt;
  logic [WC_W-1:0]  word_cnt;

  logic [ACC_W-1:0] acc_base;
  logic [FW-1:0]    fill_base;
  logic [ACC_W-1:0] acc_sum;
  logic [FS_W-1:0]  fill_sum;
  logic [ACC_W-1:0] acc_next;
  logic [FW-1:0]    fill_next;
  logic             word_done;

  logic [FF_W-1:0]  ff_wr_data;
  logic [FF_W-1:0]  ff_head;
  logic             ff_full;
  logic             ff_empty;
  logic             ff_rd;

  // Packing datapath. A new codeword always starts from an empty
  // accumulator; after the last symbol fill is already zero, so forcing it
  // in IDLE only guards against carry-over if the stream was ever cut short.
  always_comb begin
    acc_base  = (state == IDLE) ? '0 : acc;
    fill_base = (state == IDLE) ? '0 : fill;
    acc_sum   = acc_base | (ACC_W'(data_in) << fill_base);
    fill_sum  = {1'b0, fill_base} + FS_W'(SYM_W);
    word_done = valid_in && (fill_sum >= FS_W'(OUT_W));
    acc_next  = acc_sum;
    fill_next = fill_sum[FW-1:0];
    if (word_done) begin
      acc_next  = acc_sum >> OUT_W;
      fill_next = FW'(fill_sum - FS_W'(OUT_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      fill     <= '0;
      sym_cnt  <= '0;
      word_cnt <= '0;
    end else if (valid_in) begin
      acc  <= acc_next;
      fill <= fill_next;
      case (state)
        IDLE: begin
          sym_cnt <= SC_W'(1);
          state   <= RUN;
        end
        RUN: begin
          if (sym_cnt == SC_W'(N - 1)) begin
            sym_cnt <= '0;
            state   <= IDLE;
          end else begin
            sym_cnt <= sym_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // word_cnt advances even when the FIFO drops the word, so sop/eop
      // tagging stays locked to the codeword after an overflow.
      if (word_done) begin
        word_cnt <= (word_cnt == WC_W'(WORDS - 1)) ? '0 : word_cnt + 1'b1;
      end
    end
  end

  assign ff_wr_data = {(word_cnt == WC_W'(WORDS - 1)), (word_cnt == '0), acc_sum[OUT_W-1:0]};
  assign ff_rd      = out_valid && out_ready;

  fec_sync_fifo #(
    .WIDTH (FF_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (word_done),
    .wr_data (ff_wr_data),
    .rd_en   (ff_rd),
    .rd_data (ff_head),
    .full    (ff_full),
    .empty   (ff_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (word_done && ff_full && !ff_rd) begin
      overflow <= 1'b1;
    end
  end

  // Storage keeps stale tags after a pop, so the flags are qualified by
  // a non-empty FIFO.
  assign out_valid = !ff_empty;
  assign out_data  = ff_head[OUT_W-1:0];
  assign out_sop   = ff_head[OUT_W] && !ff_empty;
  assign out_eop   = ff_head[OUT_W+1] && !ff_empty;
  assign busy      = (state == RUN);

endmodule

// File: tb/tb_rs_cw_gearbox.sv
module tb_rs_cw_gearbox;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [9:0]  data_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic        overflow;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          mode;   // 0 ramp, 1 all ones, 2 all zeros
    bit          gaps;
    logic [63:0] exp_w0;
    logic [63:0] exp_w84;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic        sop;
    logic        eop;
  } word_t;

  logic [65:0] exp_q[$];      // {eop, sop, data}
  int          exp_cyc_q[$];  // expected arrival cycle, -1 = not checked
  word_t       cap[$];
  vec_t        tbl[3];

  localparam logic [63:0] RAMP_W0  = 64'h6014_0400_C020_0400;
  localparam logic [63:0] RAMP_W84 = 64'h87E1_E876_1C86_E1A8;
  localparam logic [63:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;

  rs_cw_gearbox dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .overflow  (overflow),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] sym_of(input int mode, input int k);
    logic [31:0] kv;
    kv = k;
    case (mode)
      0:       return kv[9:0];
      1:       return 10'h3FF;
      default: return 10'h000;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Drives the first nsym symbols of a codeword; when push is set the
  // scoreboard gets each word (sliced from a flat codeword bit image) as
  // soon as the symbol carrying its last bit is driven.
  task automatic send_cw(input int mode, input bit gaps, input int nsym, input bit push);
    logic [5439:0] bits;
    int w;
    int g;
    for (int k = 0; k < 544; k++) bits[10*k +: 10] = sym_of(mode, k);
    for (int k = 0; k < nsym; k++) begin
      g = 0;
      while (gaps && g < 3 && $urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        valid_in = 1'b0;
        g++;
      end
      @(posedge clk); #1;
      if (k == 0) chk("busy_idle_at_sym0", busy, 0);
      if (k == 1) chk("busy_run_after_sym0", busy, 1);
      valid_in = 1'b1;
      data_in  = sym_of(mode, k);
      if (push && ((10*k + 10) / 64) != ((10*k) / 64)) begin
        w = (10*k + 10) / 64 - 1;
        exp_q.push_back({(w == 84), (w == 0), bits[64*w +: 64]});
        exp_cyc_q.push_back(cyc + 1);
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  task automatic finish_cw();
    @(posedge clk); #1;
    valid_in = 1'b0;
    drain();
  endtask

  task automatic chk_cw(input string tag, input logic [63:0] w0, input logic [63:0] w84);
    int ns;
    int ne;
    chk({tag, "_word_count"}, cap.size(), 85);
    if (cap.size() == 85) begin
      ns = 0;
      ne = 0;
      foreach (cap[i]) begin
        if (cap[i].sop) ns++;
        if (cap[i].eop) ne++;
      end
      chk({tag, "_w0"}, cap[0].d, w0);
      chk({tag, "_w84"}, cap[84].d, w84);
      chk({tag, "_w0_sop"}, cap[0].sop, 1);
      chk({tag, "_w84_eop"}, cap[84].eop, 1);
      chk({tag, "_sop_count"}, ns, 1);
      chk({tag, "_eop_count"}, ne, 1);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [65:0] e;
    int          lc;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      cap.push_back('{out_data, out_sop, out_eop});
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got=%h want=none", out_data);
      end else begin
        e  = exp_q.pop_front();
        lc = exp_cyc_q.pop_front();
        chk("word_data", out_data, e[63:0]);
        chk("word_sop", out_sop, e[64]);
        chk("word_eop", out_eop, e[65]);
        if (lc >= 0) chk("word_latency", cyc, lc);
      end
    end
  end

  // ---------------- test ----------------
  initial begin
    tbl[0] = '{0, 1'b0, RAMP_W0, RAMP_W84};
    tbl[1] = '{1, 1'b0, ONES, ONES};
    tbl[2] = '{0, 1'b1, RAMP_W0, RAMP_W84};

    rst       = 1'b1;
    valid_in  = 1'b0;
    data_in   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sop", out_sop, 0);
    chk("rst_out_eop", out_eop, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Single codewords from the table, drained between entries.
    for (int i = 0; i < 3; i++) begin
      cap.delete();
      send_cw(tbl[i].mode, tbl[i].gaps, 544, 1'b1);
      finish_cw();
      chk_cw($sformatf("tbl%0d", i), tbl[i].exp_w0, tbl[i].exp_w84);
      chk("tbl_busy_after_cw", busy, 0);
      chk("tbl_overflow", overflow, 0);
    end

    // Back-to-back ramp then all-zero codeword: no carry-over into word 0.
    cap.delete();
    send_cw(0, 1'b0, 544, 1'b1);
    send_cw(2, 1'b0, 544, 1'b1);
    finish_cw();
    chk("b2b_word_count", cap.size(), 170);
    if (cap.size() == 170) begin
      chk("b2b_first_w84_eop", cap[84].eop, 1);
      chk("b2b_second_w0", cap[85].d, 0);
      chk("b2b_second_w0_sop", cap[85].sop, 1);
      chk("b2b_second_w84_eop", cap[169].eop, 1);
    end

    // Backpressure: out_ready low for a whole all-ones codeword.
    cap.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 544; k++) begin
      @(posedge clk); #1;
      if (k == 31) chk("bp_overflow_before_5th", overflow, 0);
      if (k == 32) chk("bp_overflow_after_5th", overflow, 1);
      valid_in = 1'b1;
      data_in  = 10'h3FF;
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    chk("bp_out_valid_held", out_valid, 1);
    chk("bp_head_sop", out_sop, 1);
    chk("bp_head_data", out_data, ONES);
    chk("bp_overflow_sticky", overflow, 1);
    chk("bp_nothing_read", cap.size(), 0);
    exp_q.push_back({1'b0, 1'b1, ONES});
    exp_cyc_q.push_back(-1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, 1'b0, ONES});
      exp_cyc_q.push_back(-1);
    end
    out_ready = 1'b1;
    drain();
    chk("bp_drained_words", cap.size(), 4);
    chk("bp_empty_after_drain", out_valid, 0);
    chk("bp_overflow_kept", overflow, 1);

    // Reset in the middle of a codeword, with valid_in high on the reset edge.
    cap.delete();
    send_cw(0, 1'b0, 301, 1'b1);
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    chk("mid_pending_before_rst", exp_q.size(), 0);
    chk("mid_busy_before_rst", busy, 1);
    rst      = 1'b1;
    valid_in = 1'b1;
    data_in  = 10'h155;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_sop", out_sop, 0);
    chk("mid_rst_out_eop", out_eop, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_busy", busy, 0);
    rst      = 1'b0;
    valid_in = 1'b0;
    cap.delete();
    send_cw(0, 1'b0, 544, 1'b1);
    finish_cw();
    chk_cw("post_rst", RAMP_W0, RAMP_W84);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
